// File: rtl/i2c_target_rx.sv
// I2C target receiver: samples SCL/SDA, detects START/STOP, shifts bytes MSB-first,
// drives ACK/NACK on the 9th clock and hands accepted bytes to the fabric as pulses.
module i2c_target_rx #(
  parameter bit         ADDR_EN = 1'b0,
  parameter logic [6:0] ADDR    = 7'h48
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_busy,
  output logic       o_start,
  output logic       o_stop
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  state_t state, state_d;

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  logic [3:0] bit_cnt, bit_cnt_d;
  logic [7:0] shift, shift_d;
  logic       ack_q, ack_d;
  logic       sda_oe_d, valid_d, busy_d, start_d, stop_d;
  logic [7:0] rx_data_d;

  logic       ev_start, ev_stop, ev_rise, ev_fall;
  logic [7:0] shift_next;
  logic       ack_now;

  // Synchronizer chain resets to the idle (pulled-up) level so leaving reset
  // on a quiet bus never fabricates a START or STOP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {scl_meta, scl_sync, scl_prev} <= 3'b111;
      {sda_meta, sda_sync, sda_prev} <= 3'b111;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // which is what turns these three assignments into a true shift chain.
      {scl_meta, scl_sync, scl_prev} <= {i_scl, scl_meta, scl_sync};
      {sda_meta, sda_sync, sda_prev} <= {i_sda, sda_meta, sda_sync};
    end
  end

  assign ev_start   = scl_sync &  sda_prev & ~sda_sync;
  assign ev_stop    = scl_sync & ~sda_prev &  sda_sync;
  assign ev_rise    = ~scl_prev &  scl_sync;
  assign ev_fall    =  scl_prev & ~scl_sync;
  assign shift_next = {shift[6:0], sda_sync};
  assign ack_now    = (state == S_ADDR) ? ((shift_next[7:1] == ADDR) && !shift_next[0])
                                        : i_rx_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state logic; bus conditions outrank clock edges
  always_comb begin
    state_d = state;
    if (ev_start) begin
      state_d = ADDR_EN ? S_ADDR : S_DATA;
    end else if (ev_stop) begin
      state_d = S_IDLE;
    end else if (ev_fall) begin
      unique case (state)
        S_ADDR:     if (bit_cnt == 4'd8) state_d = S_ADDR_ACK;
        S_DATA:     if (bit_cnt == 4'd8) state_d = S_DATA_ACK;
        S_ADDR_ACK: state_d = ack_q ? S_DATA : S_IGNORE;
        S_DATA_ACK: state_d = S_DATA;
        default:    state_d = state;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    ack_d     = ack_q;
    sda_oe_d  = o_sda_oe;
    rx_data_d = o_rx_data;
    valid_d   = 1'b0;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    busy_d    = o_busy;
    if (ev_start) begin
      start_d   = 1'b1;
      busy_d    = 1'b1;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (ev_stop) begin
      stop_d    = 1'b1;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state)
        S_ADDR, S_DATA: begin
          if (ev_rise && bit_cnt < 4'd8) begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ack_d = ack_now;
              if (state == S_DATA && i_rx_ready) begin
                rx_data_d = shift_next;
                valid_d   = 1'b1;
              end
            end
          end else if (ev_fall && bit_cnt == 4'd8) begin
            sda_oe_d = ack_q;
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          if (ev_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  // NOTE: reset is synchronous, so o_sda_oe releases on the first edge that sees i_rst.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt    <= 4'd0;
      shift      <= 8'd0;
      ack_q      <= 1'b0;
      o_sda_oe   <= 1'b0;
      o_rx_data  <= 8'd0;
      o_rx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_start    <= 1'b0;
      o_stop     <= 1'b0;
    end else begin
      bit_cnt    <= bit_cnt_d;
      shift      <= shift_d;
      ack_q      <= ack_d;
      o_sda_oe   <= sda_oe_d;
      o_rx_data  <= rx_data_d;
      o_rx_valid <= valid_d;
      o_busy     <= busy_d;
      o_start    <= start_d;
      o_stop     <= stop_d;
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench: one bus initiator drives two targets (ADDR_EN=0 and ADDR_EN=1, ADDR=7'h48);
// a transaction-level model predicts ACKs and delivered bytes for each.
module tb_i2c_target_rx;

  localparam int Q = 10;  // quarter SCL period in i_clk cycles

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic       rst, scl, m_sda, rdy_a, rdy_b;
  logic       oe_a, oe_b, valid_a, valid_b, busy_a, busy_b;
  logic       start_a, start_b, stop_a, stop_b;
  logic [7:0] data_a, data_b;
  logic       sda_a, sda_b;

  // Open-drain wired-AND of initiator and each target
  assign sda_a = m_sda & ~oe_a;
  assign sda_b = m_sda & ~oe_b;

  i2c_target_rx #(.ADDR_EN(1'b0), .ADDR(7'h48)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_sda(sda_a), .o_sda_oe(oe_a),
    .o_rx_data(data_a), .o_rx_valid(valid_a), .i_rx_ready(rdy_a),
    .o_busy(busy_a), .o_start(start_a), .o_stop(stop_a));

  i2c_target_rx #(.ADDR_EN(1'b1), .ADDR(7'h48)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_sda(sda_b), .o_sda_oe(oe_b),
    .o_rx_data(data_b), .o_rx_valid(valid_b), .i_rx_ready(rdy_b),
    .o_busy(busy_b), .o_start(start_b), .o_stop(stop_b));

  int errors = 0;
  int checks = 0;

  // Model state
  bit         b_addr, b_ign, win_a, win_b;
  logic [7:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
  logic [7:0] last_a = 8'd0, last_b = 8'd0;
  int         st_a, st_b, sp_a, sp_b, exp_starts;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Per-cycle compare: SDA only pulled during a predicted ACK, pulses collected
  always @(negedge clk) begin
    check("oe_a_outside_ack", oe_a & ~win_a, 1'b0);
    check("oe_b_outside_ack", oe_b & ~win_b, 1'b0);
    if (valid_a) got_a.push_back(data_a);
    if (valid_b) got_b.push_back(data_b);
    st_a += int'(start_a);
    st_b += int'(start_b);
    sp_a += int'(stop_a);
    sp_b += int'(stop_b);
  end

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl) begin
      m_sda = 1'b0; wait_q(2); scl = 1'b0;
    end else begin
      wait_q(1); m_sda = 1'b1; wait_q(1); scl = 1'b1;
      wait_q(1); m_sda = 1'b0; wait_q(1); scl = 1'b0;
    end
    exp_starts++;
    b_addr = 1'b1;
    b_ign  = 1'b0;
  endtask

  task automatic bus_stop();
    wait_q(1); m_sda = 1'b0; wait_q(1); scl = 1'b1;
    wait_q(1); m_sda = 1'b1; wait_q(2);
  endtask

  task automatic send_bit(input logic v);
    wait_q(1); m_sda = v; wait_q(1); scl = 1'b1; wait_q(2); scl = 1'b0;
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_bit(b[7-i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ra, input logic rb,
                           input bit rst_in_ack = 1'b0);
    bit ack_a, ack_b, dat_b;
    rdy_a = ra;
    rdy_b = rb;
    ack_a = ra;
    if (b_addr) begin
      ack_b  = (b == 8'h90);
      dat_b  = 1'b0;
      b_ign  = !ack_b;
      b_addr = 1'b0;
    end else if (b_ign) begin
      ack_b = 1'b0; dat_b = 1'b0;
    end else begin
      ack_b = rb; dat_b = rb;
    end
    if (ack_a) begin exp_a.push_back(b); last_a = b; end
    if (dat_b) begin exp_b.push_back(b); last_b = b; end
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    win_a = ack_a;
    win_b = ack_b;
    wait_q(1); m_sda = 1'b1; wait_q(1); scl = 1'b1; wait_q(1);
    check("ack_line_a", sda_a, !ack_a);
    check("ack_line_b", sda_b, !ack_b);
    check("busy_a_in_txn", busy_a, 1'b1);
    check("busy_b_in_txn", busy_b, 1'b1);
    if (rst_in_ack) begin
      rst = 1'b1;
      @(negedge clk);
      check("rst_outs_a", {oe_a, data_a, valid_a, busy_a, start_a, stop_a}, 0);
      check("rst_outs_b", {oe_b, data_b, valid_b, busy_b, start_b, stop_b}, 0);
      win_a = 1'b0; win_b = 1'b0;
      last_a = 8'd0; last_b = 8'd0;
      @(negedge clk);
      rst = 1'b0;
      wait_q(1);
      scl = 1'b0;
    end else begin
      wait_q(1);
      scl = 1'b0;
    end
    repeat (6) @(negedge clk);
    win_a = 1'b0;
    win_b = 1'b0;
  endtask

  task automatic check_txn();
    repeat (8) @(negedge clk);
    check("valid_count_a", got_a.size(), exp_a.size());
    check("valid_count_b", got_b.size(), exp_b.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) check("rx_byte_a", got_a[i], exp_a[i]);
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) check("rx_byte_b", got_b[i], exp_b[i]);
    check("start_pulses_a", st_a, exp_starts);
    check("start_pulses_b", st_b, exp_starts);
    check("stop_pulses_a", sp_a, 1);
    check("stop_pulses_b", sp_b, 1);
    check("busy_a_idle", busy_a, 1'b0);
    check("busy_b_idle", busy_b, 1'b0);
    check("held_data_a", data_a, last_a);
    check("held_data_b", data_b, last_b);
    exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
    st_a = 0; st_b = 0; sp_a = 0; sp_b = 0; exp_starts = 0;
  endtask

  initial begin
    int segs, nb;
    logic [7:0] rb8;
    rst = 1'b1; scl = 1'b1; m_sda = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    st_a = 0; st_b = 0; sp_a = 0; sp_b = 0; exp_starts = 0;
    repeat (3) @(negedge clk);
    check("reset_outs_a", {oe_a, data_a, valid_a, busy_a, start_a, stop_a}, 0);
    check("reset_outs_b", {oe_b, data_b, valid_b, busy_b, start_b, stop_b}, 0);
    rst = 1'b0;
    wait_q(2);

    // 1: single byte accepted
    bus_start(); send_byte(8'h96, 1'b1, 1'b1); bus_stop();
    check("t1_got_a_size", got_a.size(), 1);
    if (got_a.size() > 0) check("t1_got_a", got_a[0], 8'h96);
    check_txn();
    check("t1_data_a", data_a, 8'h96);

    // 2: sink not ready -> NACK, data held
    bus_start(); send_byte(8'h69, 1'b0, 1'b0); bus_stop();
    check_txn();
    check("t2_data_a_held", data_a, 8'h96);

    // 3: address match, two data bytes
    bus_start();
    send_byte(8'h90, 1'b1, 1'b1); send_byte(8'hA5, 1'b1, 1'b1); send_byte(8'h3C, 1'b1, 1'b1);
    bus_stop();
    check("t3_got_b_size", got_b.size(), 2);
    if (got_b.size() == 2) begin
      check("t3_got_b0", got_b[0], 8'hA5);
      check("t3_got_b1", got_b[1], 8'h3C);
    end
    check_txn();

    // 4: address mismatch, then read request
    bus_start(); send_byte(8'h92, 1'b1, 1'b1); send_byte(8'h11, 1'b1, 1'b1); bus_stop();
    check("t4a_got_b_size", got_b.size(), 0);
    check_txn();
    bus_start(); send_byte(8'h91, 1'b1, 1'b1); send_byte(8'h22, 1'b1, 1'b1); bus_stop();
    check("t4b_got_b_size", got_b.size(), 0);
    check_txn();

    // 5: repeated START after four bits
    bus_start(); send_partial(8'hF0, 4); bus_start(); send_byte(8'h5A, 1'b1, 1'b1); bus_stop();
    check("t5_got_a_size", got_a.size(), 1);
    if (got_a.size() > 0) check("t5_got_a", got_a[0], 8'h5A);
    check_txn();

    // 6: reset while ACK is driven, then a fresh transfer
    bus_start(); send_byte(8'h90, 1'b1, 1'b1); send_byte(8'h77, 1'b1, 1'b1, 1'b1); bus_stop();
    check_txn();
    bus_start(); send_byte(8'h90, 1'b1, 1'b1); send_byte(8'h33, 1'b1, 1'b1); bus_stop();
    check_txn();
    check("t6_data_a", data_a, 8'h33);
    check("t6_data_b", data_b, 8'h33);

    // Randomized transactions
    for (int t = 0; t < 12; t++) begin
      segs = int'($urandom_range(1, 2));
      for (int s = 0; s < segs; s++) begin
        bus_start();
        nb = int'($urandom_range(1, 3));
        for (int k = 0; k < nb; k++) begin
          rb8 = 8'($urandom);
          if (k == 0 && ($urandom % 2) == 0) rb8 = 8'h90;
          send_byte(rb8, 1'($urandom), 1'($urandom));
        end
        if (s < segs - 1 && ($urandom % 2) == 0)
          send_partial(8'($urandom), int'($urandom_range(1, 6)));
      end
      bus_stop();
      check_txn();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
